// File: rtl/pkt_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pkt_ram_ctrl
// Purpose  : Byte-stream packet engine that writes and reads wide RAM words.
//            Packet = CMD, ADDR_HI, ADDR_LO, then payload (writes only).
//            CMD[MSB] selects read (1) or write (0); CMD[MSB-1:0] = word count.
//            Writes pack beats little-endian into one word and commit it.
//            Reads fetch one word and stream its bytes out low-first.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_ram_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int WORD_BYTES  = 64,
    parameter int ADDR_WIDTH  = 12,
    parameter int RAM_LATENCY = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    // command / payload stream
    input  logic [DATA_WIDTH-1:0]            rx_data,
    input  logic                             rx_valid,
    output logic                             rx_ready,
    // read-back stream
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    // RAM port
    output logic                             we,
    output logic [ADDR_WIDTH-1:0]            addr,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] dout,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] din,
    // status
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int c_RAM_W  = DATA_WIDTH * WORD_BYTES;
    localparam int c_CNT_W  = DATA_WIDTH - 1;
    localparam int c_BEAT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(WORD_BYTES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0]  c_WORDS_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_WORDS_NIL = '0;
    // RD_WAIT counts down to zero; it lasts RAM_LATENCY-1 cycles
    localparam logic [1:0]          c_LAT_INIT  = 2'(RAM_LATENCY - 2);

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_ADDR_HI    = 3'd1;
    localparam logic [2:0] c_ST_ADDR_LO    = 3'd2;
    localparam logic [2:0] c_ST_WR_COLLECT = 3'd3;
    localparam logic [2:0] c_ST_WR_COMMIT  = 3'd4;
    localparam logic [2:0] c_ST_RD_ISSUE   = 3'd5;
    localparam logic [2:0] c_ST_RD_WAIT    = 3'd6;
    localparam logic [2:0] c_ST_RD_SEND    = 3'd7;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  r_is_rd;
    logic [c_CNT_W-1:0]    r_words;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [1:0]            r_lat;
    logic [c_TO_W-1:0]     r_idle;
    logic [c_RAM_W-1:0]    r_rd_sh;
    logic [c_RAM_W-1:0]    w_rd_shifted;
    logic [ADDR_WIDTH-1:0] w_base;

    logic w_rx_acc;
    logic w_tx_acc;
    logic w_beat_last;
    logic w_word_last;
    logic w_timed;
    logic w_to_hit;
    logic w_capture;

    assign w_rx_acc     = rx_valid && rx_ready;
    assign w_tx_acc     = tx_valid && tx_ready;
    assign w_beat_last  = (r_beat == c_BEAT_LAST);
    assign w_word_last  = (r_words == c_WORDS_ONE);
    assign w_rd_shifted = r_rd_sh >> DATA_WIDTH;
    // inactivity is only an error while the sender still owes us beats
    assign w_timed      = (r_state == c_ST_ADDR_HI) || (r_state == c_ST_ADDR_LO) ||
                          (r_state == c_ST_WR_COLLECT);
    assign w_to_hit     = (TIMEOUT != 0) && w_timed && !w_rx_acc && (r_idle == c_TO_LAST);
    assign w_capture    = (w_state_nxt == c_ST_RD_SEND) && (r_state != c_ST_RD_SEND);

    // Upper address bits come from ADDR_HI only when the address is wider than a beat
    generate
        if (ADDR_WIDTH > DATA_WIDTH) begin : g_addr_hi
            localparam int c_HI_W = ADDR_WIDTH - DATA_WIDTH;
            logic [c_HI_W-1:0] r_addr_hi;

            // Hold the high address byte until ADDR_LO arrives
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_addr_hi <= '0;
                end else if ((r_state == c_ST_ADDR_HI) && w_rx_acc) begin
                    r_addr_hi <= rx_data[c_HI_W-1:0];
                end
            end

            assign w_base = {r_addr_hi, rx_data};
        end else begin : g_addr_lo
            assign w_base = rx_data[ADDR_WIDTH-1:0];
        end
    endgenerate

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rx_acc) w_state_nxt = c_ST_ADDR_HI;
            end
            c_ST_ADDR_HI: begin
                if (w_rx_acc)      w_state_nxt = c_ST_ADDR_LO;
                else if (w_to_hit) w_state_nxt = c_ST_IDLE;
            end
            c_ST_ADDR_LO: begin
                if (w_rx_acc) begin
                    if (r_words == c_WORDS_NIL) w_state_nxt = c_ST_IDLE;
                    else if (r_is_rd)           w_state_nxt = c_ST_RD_ISSUE;
                    else                        w_state_nxt = c_ST_WR_COLLECT;
                end else if (w_to_hit) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WR_COLLECT: begin
                if (w_rx_acc && w_beat_last) w_state_nxt = c_ST_WR_COMMIT;
                else if (w_to_hit)           w_state_nxt = c_ST_IDLE;
            end
            c_ST_WR_COMMIT: begin
                w_state_nxt = w_word_last ? c_ST_IDLE : c_ST_WR_COLLECT;
            end
            c_ST_RD_ISSUE: begin
                w_state_nxt = (RAM_LATENCY == 1) ? c_ST_RD_SEND : c_ST_RD_WAIT;
            end
            c_ST_RD_WAIT: begin
                if (r_lat == 2'd0) w_state_nxt = c_ST_RD_SEND;
            end
            c_ST_RD_SEND: begin
                if (w_tx_acc && w_beat_last) begin
                    w_state_nxt = w_word_last ? c_ST_IDLE : c_ST_RD_ISSUE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register and control outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            rx_ready <= (w_state_nxt == c_ST_IDLE)    || (w_state_nxt == c_ST_ADDR_HI) ||
                        (w_state_nxt == c_ST_ADDR_LO) || (w_state_nxt == c_ST_WR_COLLECT);
            tx_valid <= (w_state_nxt == c_ST_RD_SEND);
            we       <= (w_state_nxt == c_ST_WR_COMMIT);
            busy     <= (w_state_nxt != c_ST_IDLE);
            // a packet ends well only from a data state; from a header/collect
            // state it is either N=0 or a timeout, both reported as err
            done     <= (w_state_nxt == c_ST_IDLE) &&
                        ((r_state == c_ST_WR_COMMIT) || (r_state == c_ST_RD_SEND));
            err      <= (w_state_nxt == c_ST_IDLE) && w_timed;
        end
    end

    // Datapath: command capture, word packing, address stepping, read shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_rd <= 1'b0;
            r_words <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_rd_sh <= '0;
            addr    <= '0;
            dout    <= '0;
            tx_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rx_acc) begin
                        r_is_rd <= rx_data[DATA_WIDTH-1];
                        r_words <= rx_data[DATA_WIDTH-2:0];
                        r_beat  <= '0;
                    end
                end
                c_ST_ADDR_LO: begin
                    if (w_rx_acc) begin
                        addr   <= w_base;
                        r_beat <= '0;
                    end
                end
                c_ST_WR_COLLECT: begin
                    if (w_rx_acc) begin
                        dout[r_beat*DATA_WIDTH +: DATA_WIDTH] <= rx_data;
                        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
                    end else if (w_to_hit) begin
                        r_beat <= '0;
                    end
                end
                c_ST_WR_COMMIT: begin
                    addr    <= addr + 1'b1;
                    r_words <= r_words - 1'b1;
                end
                c_ST_RD_ISSUE: begin
                    r_lat <= c_LAT_INIT;
                end
                c_ST_RD_WAIT: begin
                    if (r_lat != 2'd0) r_lat <= r_lat - 1'b1;
                end
                c_ST_RD_SEND: begin
                    if (w_tx_acc) begin
                        if (w_beat_last) begin
                            r_beat  <= '0;
                            addr    <= addr + 1'b1;
                            r_words <= r_words - 1'b1;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_rd_sh <= w_rd_shifted;
                            tx_data <= w_rd_shifted[DATA_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase

            // RAM word is sampled at the end of the final wait cycle
            if (w_capture) begin
                r_rd_sh <= din;
                tx_data <= din[DATA_WIDTH-1:0];
                r_beat  <= '0;
            end
        end
    end

    // Idle-cycle counter for the stream-receiving states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if ((TIMEOUT != 0) && w_timed && !w_rx_acc && !w_to_hit) begin
            r_idle <= r_idle + 1'b1;
        end else begin
            r_idle <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_ram_ctrl
// Purpose  : Directed self-checking bench for pkt_ram_ctrl with a behavioural
//            RAM (read data valid in the same cycle the address is held).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_ram_ctrl;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         we;
    logic [11:0]  addr;
    logic [511:0] dout;
    logic [511:0] din;
    logic         busy;
    logic         done;
    logic         err;

    logic [511:0] mem [0:4095];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int stall_cnt = 0;
    int stab_viol = 0;
    logic [11:0]  we_addr_q [$];
    logic [511:0] we_data_q [$];
    logic [7:0]   tx_q [$];
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_data = '0;

    pkt_ram_ctrl #(
        .DATA_WIDTH (8),
        .WORD_BYTES (64),
        .ADDR_WIDTH (12),
        .RAM_LATENCY(1),
        .TIMEOUT    (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .we      (we),
        .addr    (addr),
        .dout    (dout),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign din = mem[addr];

    always @(posedge clk) begin
        if (we) mem[addr] <= dout;
    end

    // Event monitor, sampled mid-cycle when all DUT outputs are settled
    always @(negedge clk) begin
        if (rst_n) begin
            if (we) begin
                we_cnt++;
                we_addr_q.push_back(addr);
                we_data_q.push_back(dout);
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (prev_stall) begin
                stall_cnt++;
                if (!tx_valid || (tx_data !== prev_data)) stab_viol++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        rx_data  = d;
        rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rx_ready_wait", ok, 1'b1);
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
        check(tag, done_cnt, target);
        @(posedge clk);
        #2;
    endtask

    task automatic check_rd_seq(input string tag);
        logic [7:0] v;
        check({tag, "_len"}, tx_q.size(), 128);
        for (int i = 0; i < 128; i++) begin
            v = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            check($sformatf("%s_beat%0d", tag, i), v, 8'(i));
        end
    endtask

    logic [511:0] exp_w;
    int           base_done;
    int           base_err;
    int           base_we;
    int           hit_k;

    initial begin
        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;

        // ---------------- reset state ----------------
        #3;
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", addr, 12'h000);
        check("rst_dout", dout, '0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_we_done_err", {we, done, err}, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_rx_ready_low", rx_ready, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst_rx_ready_rise", rx_ready, 1'b1);
        @(posedge clk);
        #2;

        // ---------------- write 2 words at 5 ----------------
        send_beat(8'h02);
        send_beat(8'h00);
        send_beat(8'h05);
        for (int i = 0; i < 128; i++) send_beat(8'(i));
        wait_done(1, "wr_done");
        check("wr_we_cnt", we_cnt, 2);
        check("wr_addr0", we_addr_q[0], 12'h005);
        check("wr_addr1", we_addr_q[1], 12'h006);
        for (int k = 0; k < 64; k++) exp_w[k*8 +: 8] = 8'(k);
        check("wr_data0", we_data_q[0], exp_w);
        for (int k = 0; k < 64; k++) exp_w[k*8 +: 8] = 8'(k + 64);
        check("wr_data1", we_data_q[1], exp_w);
        check("wr_busy_after", busy, 1'b0);

        // ---------------- read back, no stall ----------------
        tx_ready = 1'b1;
        tx_q.delete();
        send_beat(8'h82);
        send_beat(8'h00);
        send_beat(8'h05);
        wait_done(2, "rd_done");
        check_rd_seq("rd");
        check("rd_no_we", we_cnt, 2);

        // ---------------- read back with back-pressure ----------------
        tx_ready = 1'b0;
        tx_q.delete();
        stall_cnt = 0;
        stab_viol = 0;
        send_beat(8'h82);
        send_beat(8'h00);
        send_beat(8'h05);
        for (int c = 0; c < 3000 && done_cnt < 3; c++) begin
            tx_ready = ((c / 3) % 2) == 1;
            @(posedge clk);
            #2;
        end
        tx_ready = 1'b1;
        check("bp_done", done_cnt, 3);
        check("bp_stalled", stall_cnt > 0, 1'b1);
        check("bp_stable", stab_viol, 0);
        check_rd_seq("bp");

        // ---------------- address wrap ----------------
        base_we = we_cnt;
        send_beat(8'h02);
        send_beat(8'h0F);
        send_beat(8'hFF);
        for (int i = 0; i < 128; i++) send_beat(8'(i) ^ 8'hA5);
        wait_done(4, "wrap_done");
        check("wrap_we_cnt", we_cnt - base_we, 2);
        check("wrap_addr0", we_addr_q[base_we], 12'hFFF);
        check("wrap_addr1", we_addr_q[base_we + 1], 12'h000);

        // ---------------- N = 0 read ----------------
        base_err = err_cnt;
        base_we  = we_cnt;
        tx_q.delete();
        send_beat(8'h80);
        send_beat(8'h00);
        send_beat(8'h00);
        check("n0_err_pulse", err, 1'b1);
        check("n0_no_done", done, 1'b0);
        @(posedge clk);
        #1;
        check("n0_err_one_cycle", err, 1'b0);
        check("n0_idle", {busy, rx_ready}, 2'b01);
        repeat (4) @(posedge clk);
        #2;
        check("n0_err_cnt", err_cnt - base_err, 1);
        check("n0_no_tx", tx_q.size(), 0);
        check("n0_no_we", we_cnt - base_we, 0);

        // ---------------- timeout mid-word ----------------
        base_err  = err_cnt;
        base_we   = we_cnt;
        base_done = done_cnt;
        send_beat(8'h01);
        send_beat(8'h00);
        send_beat(8'h20);
        for (int i = 0; i < 10; i++) send_beat(8'(i));
        hit_k = 0;
        for (int k = 1; k <= 40 && hit_k == 0; k++) begin
            @(posedge clk);
            #1;
            if (err) hit_k = k;
        end
        check("to_latency", hit_k, 16);
        check("to_busy", busy, 1'b0);
        check("to_no_we", we_cnt - base_we, 0);
        @(posedge clk);
        #2;
        check("to_err_cnt", err_cnt - base_err, 1);
        check("to_no_done", done_cnt - base_done, 0);

        // ---------------- reset mid-packet ----------------
        base_we = we_cnt;
        send_beat(8'h01);
        send_beat(8'h00);
        send_beat(8'h40);
        for (int i = 0; i < 5; i++) send_beat(8'(i));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_addr_dout", {addr, dout}, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("mid_rst_no_we", we_cnt - base_we, 0);
        check("mid_rst_idle", {busy, rx_ready}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
